frame_check: RTL and testbench
==============================

FRAME_CHECK -- requirements
Module: frame_check

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 256: maximum beats per frame, range 2..65535.
REQ-002 SHALL have port USER_CLK, input, 1: single clock for all logic.
REQ-003 SHALL have port RESET_N, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port CLEAR, input, 1: synchronous clear of counters and sticky flag.
REQ-005 SHALL have port AXI4_S_IP_RX_TDATA, input, [0:31]: received data; bit 0 is the MSB.
REQ-006 SHALL have port AXI4_S_IP_RX_TKEEP, input, [0:3]: byte enables; TKEEP[0] qualifies TDATA[0:7].
REQ-007 SHALL have port AXI4_S_IP_RX_TLAST, input, 1: last beat of frame.
REQ-008 SHALL have port AXI4_S_IP_RX_TVALID, input, 1: beat valid; there is no TREADY, so every valid beat is consumed.
REQ-009 SHALL have port DATA_ERR, output, 1: one-cycle pulse for an errored beat.
REQ-010 SHALL have port ERR_FLAG, output, 1: sticky error indicator.
REQ-011 SHALL have port ERR_COUNT, output, [0:7]: errored-beat count, saturating.
REQ-012 SHALL have port FRAME_COUNT, output, [0:15]: completed-frame count, wrapping.

Function
REQ-013 SHALL define the expected word for beat n of frame f as TDATA[0:15]=f[15:0] and TDATA[16:31]=n[15:0], with n starting at 0 for each frame.
REQ-014 SHALL implement FSM states IDLE and IN_FRAME; a valid non-last beat moves IDLE->IN_FRAME; a valid TLAST beat returns the FSM to IDLE.
REQ-015 SHALL accept a valid TLAST beat in IDLE as a one-beat frame.
REQ-016 SHALL compare only bytes with TKEEP set; a mismatch in any enabled byte is a data error.
REQ-017 SHALL flag a keep error when a non-last beat has TKEEP other than 1111, or a last beat has TKEEP not in {1000,1100,1110,1111}.
REQ-018 SHALL flag a length error when a beat arrives at index n=MAX_WORDS; the FSM SHALL then force IDLE, advance the expected frame number, and treat the next beat as a frame start.
REQ-019 SHALL register all error detection: DATA_ERR asserts exactly 1 cycle after the offending beat; multiple error types on one beat produce one pulse.
REQ-020 SHALL set ERR_FLAG on the same cycle as DATA_ERR and hold it until CLEAR or reset.
REQ-021 SHALL increment ERR_COUNT by 1 per errored beat, in the same cycle as DATA_ERR, and hold it at 255.
REQ-022 SHALL increment FRAME_COUNT 1 cycle after each TLAST beat, wrapping 65535->0.
REQ-023 SHALL increment the expected frame number f after each TLAST beat, wrapping at 16 bits.
REQ-024 SHALL give CLEAR priority over a simultaneous increment: ERR_COUNT, FRAME_COUNT and ERR_FLAG become 0 and the coincident event is dropped.
REQ-025 SHALL NOT let CLEAR alter the FSM state, beat index or expected frame number.
REQ-026 SHALL ignore all inputs while TVALID=0 and hold all state.

Reset
REQ-027 SHALL, when RESET_N=0 at a USER_CLK edge, set FSM=IDLE, n=0, f=0, DATA_ERR=0, ERR_FLAG=0, ERR_COUNT=0, FRAME_COUNT=0.
REQ-028 SHALL give reset priority over CLEAR and over a valid beat; a beat coincident with reset is discarded.
REQ-029 SHALL, on reset mid-frame, discard the partial frame with no error and no frame count.

Configuration
REQ-030 SHALL support macro FRAME_CHECK_RESYNC_EN.
REQ-031 SHALL, when FRAME_CHECK_RESYNC_EN is defined, on a frame-start beat with TDATA[0:15]!=f: report the error once, load f from TDATA[0:15], and check the rest of that frame against the received number.
REQ-032 SHALL, when FRAME_CHECK_RESYNC_EN is not defined, leave f unchanged on mismatch, so that every mismatching beat counts as an error.

Verification
REQ-033 SHALL cover: reset, then frames f=0,1,2 of 4 beats each with TKEEP=1111 -> FRAME_COUNT=3, ERR_COUNT=0, DATA_ERR never asserted.
REQ-034 SHALL cover: beat 2 of frame 0 carries 0x0000_0003 -> DATA_ERR pulses 1 cycle after that beat, ERR_COUNT=1, ERR_FLAG=1.
REQ-035 SHALL cover: last beat with TKEEP=1100 and TDATA=0x0000_03FF for n=3 -> no error; the same beat with TKEEP=1010 -> keep error, ERR_COUNT=1.
REQ-036 SHALL cover: a frame of MAX_WORDS+1 beats -> one error at beat MAX_WORDS, and the next frame is checked with f advanced.
REQ-037 SHALL cover: the first frame starting with 0x0005_0000, 3 beats -> with RESYNC_EN ERR_COUNT=1 and the next frame expects 6; without RESYNC_EN ERR_COUNT=3 and the next frame expects 1.
REQ-038 SHALL cover: 300 errored beats -> ERR_COUNT=255; CLEAR coincident with a TLAST beat -> FRAME_COUNT=0 and ERR_COUNT=0 on the next cycle.

Source files
------------

// File: rtl/frame_check.sv
// frame_check: checks a 32-bit AXI4-Stream receive channel against the test
// pattern {frame_number[15:0], beat_index[15:0]}.
// It reports errored beats as a one-cycle pulse, a sticky flag and a
// saturating count, and it counts completed frames.
// Optional build macro: FRAME_CHECK_RESYNC_EN. When it is defined, a frame
// whose first beat carries an unexpected frame number re-locks onto the
// received number.
module frame_check #(
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        USER_CLK,
    input  logic        RESET_N,
    input  logic        CLEAR,
    input  logic [0:31] AXI4_S_IP_RX_TDATA,
    input  logic [0:3]  AXI4_S_IP_RX_TKEEP,
    input  logic        AXI4_S_IP_RX_TLAST,
    input  logic        AXI4_S_IP_RX_TVALID,
    output logic        DATA_ERR,
    output logic        ERR_FLAG,
    output logic [0:7]  ERR_COUNT,
    output logic [0:15] FRAME_COUNT
);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_IN_FRAME = 1'b1
    } state_t;

    localparam logic [15:0] MAX_IDX = 16'(MAX_WORDS);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] beat_idx_r;
    logic [15:0] beat_idx_nxt_s;
    logic [15:0] frame_num_r;
    logic [15:0] frame_num_nxt_s;
    logic [15:0] frame_eff_s;
    logic [0:31] exp_word_s;
    logic [0:3]  byte_mis_s;
    logic        len_err_s;
    logic        keep_err_s;
    logic        beat_err_s;
    logic        frame_done_s;

    logic        data_err_r;
    logic        err_flag_r;
    logic [7:0]  err_count_r;
    logic [15:0] frame_count_r;

    // Legal keep patterns: full words inside a frame, a left-packed tail on the last beat.
    function automatic logic keep_ok(input logic last, input logic [0:3] keep);
        logic ok;
        if (last) begin
            case (keep)
                4'b1000, 4'b1100, 4'b1110, 4'b1111: ok = 1'b1;
                default:                            ok = 1'b0;
            endcase
        end else begin
            ok = (keep == 4'b1111);
        end
        return ok;
    endfunction

    // Beat checking and next-state logic for the frame FSM, beat index and expected frame number.
    always_comb begin
        state_nxt_s     = state_r;
        beat_idx_nxt_s  = beat_idx_r;
        frame_num_nxt_s = frame_num_r;
        exp_word_s      = {frame_num_r, beat_idx_r};
        byte_mis_s      = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            byte_mis_s[i] = AXI4_S_IP_RX_TKEEP[i] &
                            (AXI4_S_IP_RX_TDATA[8*i +: 8] != exp_word_s[8*i +: 8]);
        end
`ifdef FRAME_CHECK_RESYNC_EN
        // A wrong frame number on a frame-start beat is reported once; the
        // rest of the frame is then checked against the received number.
        if ((state_r == ST_IDLE) && (byte_mis_s[0] || byte_mis_s[1])) begin
            frame_eff_s = AXI4_S_IP_RX_TDATA[0:15];
        end else begin
            frame_eff_s = frame_num_r;
        end
`else
        frame_eff_s = frame_num_r;
`endif
        // A frame-start beat always has index 0, so an oversize frame can
        // only be detected inside a frame. MAX_WORDS is at least 2.
        len_err_s    = (beat_idx_r == MAX_IDX);
        keep_err_s   = ~keep_ok(AXI4_S_IP_RX_TLAST, AXI4_S_IP_RX_TKEEP);
        beat_err_s   = AXI4_S_IP_RX_TVALID & ((|byte_mis_s) | keep_err_s | len_err_s);
        frame_done_s = AXI4_S_IP_RX_TVALID & AXI4_S_IP_RX_TLAST;
        if (AXI4_S_IP_RX_TVALID) begin
            if (len_err_s || AXI4_S_IP_RX_TLAST) begin
                // The frame ends here, either normally or forced by the length limit.
                state_nxt_s     = ST_IDLE;
                beat_idx_nxt_s  = 16'd0;
                frame_num_nxt_s = frame_eff_s + 16'd1;
            end else begin
                state_nxt_s     = ST_IN_FRAME;
                beat_idx_nxt_s  = beat_idx_r + 16'd1;
                frame_num_nxt_s = frame_eff_s;
            end
        end else begin
            state_nxt_s     = state_r;
            beat_idx_nxt_s  = beat_idx_r;
            frame_num_nxt_s = frame_num_r;
        end
    end

    // FSM state, beat index and expected frame number (CLEAR does not touch these).
    always_ff @(posedge USER_CLK) begin
        if (!RESET_N) begin
            state_r     <= ST_IDLE;
            beat_idx_r  <= 16'd0;
            frame_num_r <= 16'd0;
        end else begin
            state_r     <= state_nxt_s;
            beat_idx_r  <= beat_idx_nxt_s;
            frame_num_r <= frame_num_nxt_s;
        end
    end

    // Error pulse, sticky flag and counters; CLEAR overrides a coincident increment.
    always_ff @(posedge USER_CLK) begin
        if (!RESET_N) begin
            data_err_r    <= 1'b0;
            err_flag_r    <= 1'b0;
            err_count_r   <= 8'd0;
            frame_count_r <= 16'd0;
        end else begin
            data_err_r <= beat_err_s;
            if (CLEAR) begin
                err_flag_r    <= 1'b0;
                err_count_r   <= 8'd0;
                frame_count_r <= 16'd0;
            end else begin
                if (beat_err_s) begin
                    err_flag_r <= 1'b1;
                    if (err_count_r != 8'hFF) begin
                        err_count_r <= err_count_r + 8'd1;
                    end
                end
                if (frame_done_s) begin
                    frame_count_r <= frame_count_r + 16'd1;
                end
            end
        end
    end

    assign DATA_ERR    = data_err_r;
    assign ERR_FLAG    = err_flag_r;
    assign ERR_COUNT   = err_count_r;
    assign FRAME_COUNT = frame_count_r;

endmodule

// File: tb/tb_frame_check.sv
// Directed testbench for frame_check (MAX_WORDS = 6). The expected values
// adapt to whether FRAME_CHECK_RESYNC_EN is defined.
module tb_frame_check;

    logic        USER_CLK;
    logic        RESET_N;
    logic        CLEAR;
    logic [0:31] tdata;
    logic [0:3]  tkeep;
    logic        tlast;
    logic        tvalid;
    logic        DATA_ERR;
    logic        ERR_FLAG;
    logic [0:7]  ERR_COUNT;
    logic [0:15] FRAME_COUNT;

    int tests = 0;
    int fails = 0;

    frame_check #(.MAX_WORDS(6)) dut (
        .USER_CLK            (USER_CLK),
        .RESET_N             (RESET_N),
        .CLEAR               (CLEAR),
        .AXI4_S_IP_RX_TDATA  (tdata),
        .AXI4_S_IP_RX_TKEEP  (tkeep),
        .AXI4_S_IP_RX_TLAST  (tlast),
        .AXI4_S_IP_RX_TVALID (tvalid),
        .DATA_ERR            (DATA_ERR),
        .ERR_FLAG            (ERR_FLAG),
        .ERR_COUNT           (ERR_COUNT),
        .FRAME_COUNT         (FRAME_COUNT)
    );

    initial begin
        USER_CLK = 1'b0;
        forever #5 USER_CLK = ~USER_CLK;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one valid beat for one clock, then sits at #1 after the edge.
    task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        tdata  = d;
        tkeep  = k;
        tlast  = l;
        tvalid = 1'b1;
        @(posedge USER_CLK);
        #1;
        tvalid = 1'b0;
    endtask

    // Idle cycles with garbage on the bus that must be ignored.
    task automatic idle(input int cycles);
        tdata  = $urandom;
        tkeep  = 4'b0101;
        tlast  = 1'b1;
        tvalid = 1'b0;
        repeat (cycles) @(posedge USER_CLK);
        #1;
    endtask

    initial begin
        logic de_seen;
        logic [31:0] exp_err;
        logic [15:0] next_f;

        RESET_N = 1'b0;
        CLEAR   = 1'b0;
        tdata   = 32'hDEAD_BEEF;
        tkeep   = 4'b1111;
        tlast   = 1'b1;
        tvalid  = 1'b1;
        repeat (2) @(posedge USER_CLK);
        #1;
        RESET_N = 1'b1;
        tvalid  = 1'b0;
        check("rst_data_err", 32'(DATA_ERR), 32'd0);
        check("rst_err_flag", 32'(ERR_FLAG), 32'd0);
        check("rst_err_count", 32'(ERR_COUNT), 32'd0);
        check("rst_frame_count", 32'(FRAME_COUNT), 32'd0);

        // Frames 0..2, four clean beats each, with ignored idle garbage between.
        de_seen = 1'b0;
        for (int f = 0; f < 3; f++) begin
            for (int n = 0; n < 4; n++) begin
                beat({16'(f), 16'(n)}, 4'b1111, (n == 3));
                de_seen = de_seen | DATA_ERR;
            end
            idle(2);
        end
        check("clean_frame_count", 32'(FRAME_COUNT), 32'd3);
        check("clean_err_count", 32'(ERR_COUNT), 32'd0);
        check("clean_no_pulse", 32'(de_seen), 32'd0);
        check("clean_err_flag", 32'(ERR_FLAG), 32'd0);

        // Frame 3: partial last beat, only enabled bytes compared.
        for (int n = 0; n < 3; n++) beat({16'd3, 16'(n)}, 4'b1111, 1'b0);
        beat(32'h0003_03FF, 4'b1100, 1'b1);
        check("keep1100_no_err", 32'(DATA_ERR), 32'd0);
        check("keep1100_err_count", 32'(ERR_COUNT), 32'd0);
        check("keep1100_frame_count", 32'(FRAME_COUNT), 32'd4);

        // Frame 4: illegal last-beat keep 1010 with otherwise correct data.
        for (int n = 0; n < 3; n++) beat({16'd4, 16'(n)}, 4'b1111, 1'b0);
        beat(32'h0004_0003, 4'b1010, 1'b1);
        check("keep1010_pulse", 32'(DATA_ERR), 32'd1);
        check("keep1010_err_count", 32'(ERR_COUNT), 32'd1);
        check("keep1010_err_flag", 32'(ERR_FLAG), 32'd1);
        check("keep1010_frame_count", 32'(FRAME_COUNT), 32'd5);
        idle(1);
        check("pulse_one_cycle", 32'(DATA_ERR), 32'd0);

        // CLEAR alone zeroes counters and flag.
        CLEAR = 1'b1;
        @(posedge USER_CLK);
        #1;
        CLEAR = 1'b0;
        check("clear_err_count", 32'(ERR_COUNT), 32'd0);
        check("clear_err_flag", 32'(ERR_FLAG), 32'd0);
        check("clear_frame_count", 32'(FRAME_COUNT), 32'd0);

        // Frame 5: beat 2 carries the wrong index.
        beat(32'h0005_0000, 4'b1111, 1'b0);
        beat(32'h0005_0001, 4'b1111, 1'b0);
        check("data_before_err", 32'(DATA_ERR), 32'd0);
        beat(32'h0005_0003, 4'b1111, 1'b0);
        check("data_err_pulse", 32'(DATA_ERR), 32'd1);
        check("data_err_count", 32'(ERR_COUNT), 32'd1);
        check("data_err_flag", 32'(ERR_FLAG), 32'd1);
        beat(32'h0005_0003, 4'b1111, 1'b1);
        check("data_after_err", 32'(DATA_ERR), 32'd0);
        check("data_frame_count", 32'(FRAME_COUNT), 32'd1);

        // Frame 6: MAX_WORDS+1 beats, TLAST on the oversize beat.
        for (int n = 0; n < 6; n++) beat({16'd6, 16'(n)}, 4'b1111, 1'b0);
        check("len_last_ok_beat", 32'(DATA_ERR), 32'd0);
        beat(32'h0006_0006, 4'b1111, 1'b1);
        check("len_err_pulse", 32'(DATA_ERR), 32'd1);
        check("len_err_count", 32'(ERR_COUNT), 32'd2);
        check("len_frame_count", 32'(FRAME_COUNT), 32'd2);
        beat(32'h0007_0000, 4'b1111, 1'b0);
        beat(32'h0007_0001, 4'b1111, 1'b1);
        check("len_next_frame_ok", 32'(DATA_ERR), 32'd0);
        check("len_next_err_count", 32'(ERR_COUNT), 32'd2);

        // Frame 8: oversize beat without TLAST forces a new frame start.
        for (int n = 0; n < 7; n++) beat({16'd8, 16'(n)}, 4'b1111, 1'b0);
        check("len_nolast_pulse", 32'(DATA_ERR), 32'd1);
        check("len_nolast_frame_count", 32'(FRAME_COUNT), 32'd3);
        beat(32'h0009_0000, 4'b1111, 1'b1);
        check("len_restart_ok", 32'(DATA_ERR), 32'd0);
        check("len_restart_err_count", 32'(ERR_COUNT), 32'd3);
        check("len_restart_frame_count", 32'(FRAME_COUNT), 32'd4);

        // Reset in mid-frame with a coincident valid TLAST beat.
        beat(32'h000A_0000, 4'b1111, 1'b0);
        beat(32'h000A_0001, 4'b1111, 1'b0);
        RESET_N = 1'b0;
        tdata   = 32'h000A_0002;
        tkeep   = 4'b1111;
        tlast   = 1'b1;
        tvalid  = 1'b1;
        @(posedge USER_CLK);
        #1;
        RESET_N = 1'b1;
        tvalid  = 1'b0;
        check("midrst_err_count", 32'(ERR_COUNT), 32'd0);
        check("midrst_frame_count", 32'(FRAME_COUNT), 32'd0);
        check("midrst_err_flag", 32'(ERR_FLAG), 32'd0);
        beat(32'h0000_0000, 4'b1111, 1'b1);
        check("midrst_restart_ok", 32'(DATA_ERR), 32'd0);
        check("midrst_restart_count", 32'(FRAME_COUNT), 32'd1);

        // Frame number mismatch on the first frame after reset.
        RESET_N = 1'b0;
        @(posedge USER_CLK);
        #1;
        RESET_N = 1'b1;
`ifdef FRAME_CHECK_RESYNC_EN
        exp_err = 32'd1;
        next_f  = 16'd6;
`else
        exp_err = 32'd3;
        next_f  = 16'd1;
`endif
        beat(32'h0005_0000, 4'b1111, 1'b0);
        beat(32'h0005_0001, 4'b1111, 1'b0);
        beat(32'h0005_0002, 4'b1111, 1'b1);
        check("resync_err_count", 32'(ERR_COUNT), exp_err);
        beat({next_f, 16'd0}, 4'b1111, 1'b1);
        check("resync_next_ok", 32'(DATA_ERR), 32'd0);
        check("resync_next_count", 32'(ERR_COUNT), exp_err);
        check("resync_frame_count", 32'(FRAME_COUNT), 32'd2);

        // 300 errored one-beat frames saturate the error counter.
        for (int i = 0; i < 300; i++) beat(32'h0000_0000, 4'b0101, 1'b1);
        check("sat_err_count", 32'(ERR_COUNT), 32'd255);
        check("sat_err_flag", 32'(ERR_FLAG), 32'd1);
        check("sat_frame_count", 32'(FRAME_COUNT), 32'd302);

        // CLEAR coincident with an errored TLAST beat drops both increments.
        CLEAR = 1'b1;
        beat(32'h0000_0000, 4'b0101, 1'b1);
        CLEAR = 1'b0;
        check("clr_tlast_frame_count", 32'(FRAME_COUNT), 32'd0);
        check("clr_tlast_err_count", 32'(ERR_COUNT), 32'd0);
        check("clr_tlast_err_flag", 32'(ERR_FLAG), 32'd0);
        beat(32'h0000_0000, 4'b0101, 1'b1);
        check("post_clr_err_count", 32'(ERR_COUNT), 32'd1);
        check("post_clr_frame_count", 32'(FRAME_COUNT), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
